// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction path: opcodes, memory geometry,
// the power-on program image and the instruction-memory arbiter state encoding.
package cpu_pkg;

   localparam int unsigned IMEM_ADDR_W = 5;
   localparam int unsigned IMEM_DATA_W = 16;
   localparam int unsigned IMEM_DEPTH  = 1 << IMEM_ADDR_W;

   typedef enum logic [3:0] {
      NOP   = 4'd0,
      LOADA = 4'd1,
      LOADB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4
   } opcode_e;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Instruction word: opcode in the top nibble, operand in the low 12 bits.
   function automatic logic [IMEM_DATA_W-1:0] mk_instr(opcode_e op, logic [11:0] arg);
      return {op, arg};
   endfunction

   function automatic logic [IMEM_DATA_W-1:0] imem_init_word(int unsigned idx);
      case (idx)
         0:       return mk_instr(LOADA, 12'd15);
         1:       return mk_instr(LOADB, 12'd2);
         2:       return mk_instr(ADD,   12'd0);
         3:       return mk_instr(LOADB, 12'd6);
         4:       return mk_instr(SUB,   12'd0);
         default: return mk_instr(NOP,   12'd0);
      endcase
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Request/grant/data bundle between the two memory requesters (CPU fetch,
// program loader) and the instruction-memory arbiter.
interface imem_arbiter_if
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;

   logic              l_req;
   logic              l_we;
   logic              l_lock;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;

   logic              cpu_hold;

   modport master (
      output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_hold
   );

   modport slave (
      input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_hold
   );
endinterface

// File: rtl/imem_sp_ram.sv
// Single-port instruction RAM with synchronous read; contents power up with
// the program image and are never cleared by reset.
module imem_sp_ram
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] mem_t [DEPTH];

   function automatic mem_t build_image();
      mem_t m;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         m[i] = DATA_W'(imem_init_word(i));
      end
      return m;
   endfunction

   mem_t mem = build_image();

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the instruction RAM between CPU fetch (priority) and the program
// loader (anti-starvation counter, optional exclusive lock that holds the CPU).
module imem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = IMEM_ADDR_W,
   parameter int unsigned DATA_W   = IMEM_DATA_W,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic          clk,
   input logic          reset_n,
   imem_arbiter_if.slave bus
);
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   arb_state_e        state, state_nx;
   logic [WAIT_W-1:0] wait_cnt, wait_nx;
   logic              f_gnt, l_gnt;
   logic              f_rvalid, l_rvalid, cpu_hold;
   logic [DATA_W-1:0] f_hold, l_hold, ram_q;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;

   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      f_gnt    = 1'b0;
      l_gnt    = 1'b0;
      case (state)
         IDLE: begin
            f_gnt = bus.f_req && !(bus.l_req && wait_cnt == WAIT_W'(MAX_WAIT));
            l_gnt = bus.l_req && !f_gnt;
            if (l_gnt || !bus.l_req) begin
               wait_nx = '0;
            end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
               wait_nx = wait_cnt + 1'b1;
            end
            if (l_gnt && bus.l_lock) begin
               state_nx = LOCKED;
            end
         end
         LOCKED: begin
            l_gnt   = bus.l_req;
            wait_nx = '0;
            if (!bus.l_lock) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Read data is captured into a hold register only when it is valid, so
   // each port's rdata keeps its last value while the RAM serves the other.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         cpu_hold <= 1'b0;
         f_rvalid <= 1'b0;
         l_rvalid <= 1'b0;
         f_hold   <= '0;
         l_hold   <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         cpu_hold <= (state_nx == LOCKED);
         f_rvalid <= f_gnt;
         l_rvalid <= l_gnt && !bus.l_we;
         if (f_rvalid) f_hold <= ram_q;
         if (l_rvalid) l_hold <= ram_q;
      end
   end

   // Gating with reset_n keeps a pending write from landing while in reset.
   assign ram_en   = (f_gnt || l_gnt) && reset_n;
   assign ram_we   = l_gnt && bus.l_we;
   assign ram_addr = l_gnt ? bus.l_addr : bus.f_addr;

   imem_sp_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(bus.l_wdata),
      .rdata(ram_q)
   );

   assign bus.f_gnt    = f_gnt;
   assign bus.l_gnt    = l_gnt;
   assign bus.f_rvalid = f_rvalid;
   assign bus.l_rvalid = l_rvalid;
   assign bus.f_rdata  = f_rvalid ? ram_q : f_hold;
   assign bus.l_rdata  = l_rvalid ? ram_q : l_hold;
   assign bus.cpu_hold = cpu_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table for arbitration/lock flow,
// plus a hand-written sequence for reset asserted during a locked session.
module tb_imem_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imem_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

   imem_arbiter #(
      .ADDR_W  (5),
      .DATA_W  (16),
      .MAX_WAIT(4)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic        fr;
      logic [4:0]  fa;
      logic        lr;
      logic        lwe;
      logic        llk;
      logic [4:0]  la;
      logic [15:0] lwd;
      logic        e_fg;
      logic        e_lg;
      logic        e_frv;
      logic [15:0] e_frd;
      logic        e_lrv;
      logic [15:0] e_lrd;
      logic        e_hold;
   } vec_t;

   vec_t vecs [25];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic fr, input logic [4:0] fa, input logic lr, input logic lwe,
                        input logic llk, input logic [4:0] la, input logic [15:0] lwd);
      bus.f_req   = fr;
      bus.f_addr  = fa;
      bus.l_req   = lr;
      bus.l_we    = lwe;
      bus.l_lock  = llk;
      bus.l_addr  = la;
      bus.l_wdata = lwd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic frv, input logic [15:0] frd,
                             input logic lrv, input logic [15:0] lrd, input logic hold);
      check({tag, " f_rvalid"}, 32'(bus.f_rvalid), 32'(frv));
      check({tag, " f_rdata"},  32'(bus.f_rdata),  32'(frd));
      check({tag, " l_rvalid"}, 32'(bus.l_rvalid), 32'(lrv));
      check({tag, " l_rdata"},  32'(bus.l_rdata),  32'(lrd));
      check({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'(hold));
   endtask

   initial begin
      //          fr   fa    lr   lwe  llk  la    lwd        fg   lg   frv  frd        lrv  lrd        hold
      vecs[0]  = '{1'b1,5'd0,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h100F,1'b0,16'h0000,1'b0};
      vecs[1]  = '{1'b1,5'd1,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h2002,1'b0,16'h0000,1'b0};
      vecs[2]  = '{1'b1,5'd2,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h3000,1'b0,16'h0000,1'b0};
      vecs[3]  = '{1'b1,5'd3,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h2006,1'b0,16'h0000,1'b0};
      vecs[4]  = '{1'b1,5'd4,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h4000,1'b0,16'h0000,1'b0};
      // loader read of addr 3 starved for 4 cycles, wins on the 5th
      vecs[5]  = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd3,16'h0000, 1'b1,1'b0,1'b1,16'h100F,1'b0,16'h0000,1'b0};
      vecs[6]  = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd3,16'h0000, 1'b1,1'b0,1'b1,16'h100F,1'b0,16'h0000,1'b0};
      vecs[7]  = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd3,16'h0000, 1'b1,1'b0,1'b1,16'h100F,1'b0,16'h0000,1'b0};
      vecs[8]  = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd3,16'h0000, 1'b1,1'b0,1'b1,16'h100F,1'b0,16'h0000,1'b0};
      vecs[9]  = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd3,16'h0000, 1'b0,1'b1,1'b0,16'h100F,1'b1,16'h2006,1'b0};
      // counter back at 0: fetch wins a fresh contention
      vecs[10] = '{1'b1,5'd1,1'b1,1'b0,1'b0,5'd4,16'h0000, 1'b1,1'b0,1'b1,16'h2002,1'b0,16'h2006,1'b0};
      vecs[11] = '{1'b1,5'd2,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h3000,1'b0,16'h2006,1'b0};
      // locked write of 0x100A to addr 0 after starvation
      vecs[12] = '{1'b1,5'd3,1'b1,1'b1,1'b1,5'd0,16'h100A, 1'b1,1'b0,1'b1,16'h2006,1'b0,16'h2006,1'b0};
      vecs[13] = '{1'b1,5'd3,1'b1,1'b1,1'b1,5'd0,16'h100A, 1'b1,1'b0,1'b1,16'h2006,1'b0,16'h2006,1'b0};
      vecs[14] = '{1'b1,5'd3,1'b1,1'b1,1'b1,5'd0,16'h100A, 1'b1,1'b0,1'b1,16'h2006,1'b0,16'h2006,1'b0};
      vecs[15] = '{1'b1,5'd3,1'b1,1'b1,1'b1,5'd0,16'h100A, 1'b1,1'b0,1'b1,16'h2006,1'b0,16'h2006,1'b0};
      vecs[16] = '{1'b1,5'd3,1'b1,1'b1,1'b1,5'd0,16'h100A, 1'b0,1'b1,1'b0,16'h2006,1'b0,16'h2006,1'b1};
      vecs[17] = '{1'b1,5'd0,1'b1,1'b1,1'b1,5'd5,16'h1234, 1'b0,1'b1,1'b0,16'h2006,1'b0,16'h2006,1'b1};
      vecs[18] = '{1'b1,5'd0,1'b1,1'b0,1'b1,5'd0,16'h0000, 1'b0,1'b1,1'b0,16'h2006,1'b1,16'h100A,1'b1};
      vecs[19] = '{1'b1,5'd0,1'b0,1'b0,1'b1,5'd0,16'h0000, 1'b0,1'b0,1'b0,16'h2006,1'b0,16'h100A,1'b1};
      // unlock with l_req: served in exit cycle, fetch resumes next
      vecs[20] = '{1'b1,5'd0,1'b1,1'b0,1'b0,5'd5,16'h0000, 1'b0,1'b1,1'b0,16'h2006,1'b1,16'h1234,1'b0};
      vecs[21] = '{1'b1,5'd0,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b1,1'b0,1'b1,16'h100A,1'b0,16'h1234,1'b0};
      // loader alone: write (no rvalid) then read (rvalid next cycle)
      vecs[22] = '{1'b0,5'd0,1'b1,1'b1,1'b0,5'd6,16'hBEEF, 1'b0,1'b1,1'b0,16'h100A,1'b0,16'h1234,1'b0};
      vecs[23] = '{1'b0,5'd0,1'b1,1'b0,1'b0,5'd6,16'h0000, 1'b0,1'b1,1'b0,16'h100A,1'b1,16'hBEEF,1'b0};
      vecs[24] = '{1'b0,5'd0,1'b0,1'b0,1'b0,5'd0,16'h0000, 1'b0,1'b0,1'b0,16'h100A,1'b0,16'hBEEF,1'b0};

      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lwe, vecs[i].llk, vecs[i].la, vecs[i].lwd);
         #1;
         check($sformatf("row%0d f_gnt", i), 32'(bus.f_gnt), 32'(vecs[i].e_fg));
         check($sformatf("row%0d l_gnt", i), 32'(bus.l_gnt), 32'(vecs[i].e_lg));
         @(posedge clk);
         #1;
         check_regs($sformatf("row%0d", i), vecs[i].e_frv, vecs[i].e_frd,
                    vecs[i].e_lrv, vecs[i].e_lrd, vecs[i].e_hold);
      end

      // Reset during a locked write burst.
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 16'h7777);
      #1;
      check("rst_seq lock grant", 32'(bus.l_gnt), 32'd1);
      tick();
      check("rst_seq hold on", 32'(bus.cpu_hold), 32'd1);
      drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 16'h8888);
      tick();
      drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 16'h0000);
      tick();
      check_regs("rst_seq readback", 1'b0, 16'h100A, 1'b1, 16'h7777, 1'b1);
      drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 16'h9999);
      #1;
      check("rst_seq locked f_gnt", 32'(bus.f_gnt), 32'd0);
      reset_n = 1'b0;
      #1;
      check_regs("rst_seq async", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();
      check("rst_seq hold in reset", 32'(bus.cpu_hold), 32'd0);
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      reset_n = 1'b1;
      #1;
      check("rst_seq idle f_gnt", 32'(bus.f_gnt), 32'd1);
      tick();
      check_regs("rst_seq mem0", 1'b1, 16'h100A, 1'b0, 16'h0000, 1'b0);
      drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      check("rst_seq mem7", 32'(bus.f_rdata), 32'h7777);
      drive(1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      check("rst_seq mem8", 32'(bus.f_rdata), 32'h8888);
      drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();
      check("rst_seq mem9 aborted", 32'(bus.f_rdata), 32'h0000);
      check("rst_seq final hold", 32'(bus.cpu_hold), 32'd0);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
